// File: rtl/fetch_pkg.sv
// Shared constants and types for the 2-wide fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W               = 8;
  localparam int unsigned INST_W             = 32;
  localparam int unsigned FETCH_BYTES        = 8;
  localparam int unsigned IMEM_BYTES_DEFAULT = 128;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst1;
    logic [INST_W-1:0] inst2;
  } inst_pair_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pair_fifo.sv
// Circular queue of fetched instruction pairs; head is read combinationally.
module fetch_pair_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned QDEPTH = 2,
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1),
  localparam int unsigned PTR_W = $clog2(QDEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  inst_pair_t       push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output inst_pair_t       head
);

  inst_pair_t       mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues pair addresses, queues returned pairs, handles
// backpressure, redirects and end-of-program halt. FETCH_PERF_EN adds counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT,
  parameter int unsigned QDEPTH     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst1_in,
  input  logic [INST_W-1:0] inst2_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst1,
  output logic [INST_W-1:0] out_inst2,
  output logic [PC_W-1:0]   out_pc,
  output logic              halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_pairs,
  output logic [15:0]       perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(IMEM_BYTES - FETCH_BYTES);

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic             inflight;
  logic [PC_W-1:0]  inflight_pc;
  logic [CNT_W-1:0] count;
  inst_pair_t       head;
  inst_pair_t       push_data;

  logic             pop_c;
  logic             redirect_c;
  logic             end_c;
  logic             credit_ok_c;
  logic [SUM_W-1:0] occupancy_c;
  logic [PC_W-1:0]  redir_tgt_c;
  logic             redir_halt_c;
  logic             issue_c;
  logic             push_c;
  logic [PC_W-1:0]  pc_d;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[2:0];

  assign pop_c        = out_valid & out_ready;
  assign redirect_c   = redirect_valid && (state_q != IDLE);
  assign end_c        = inflight && (inst1_in == '0);
  assign occupancy_c  = SUM_W'(count) + SUM_W'(inflight) - SUM_W'(pop_c);
  assign credit_ok_c  = occupancy_c < SUM_W'(QDEPTH);
  assign redir_tgt_c  = {redirect_pc[PC_W-1:3], 3'b000};
  assign redir_halt_c = redir_tgt_c > LAST_PC;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; redirect outranks end-of-program detection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (redirect_c)                                state_d = redir_halt_c ? HALT : RUN;
        else if (end_c || (issue_c && pc == LAST_PC))  state_d = HALT;
      end
      HALT: if (redirect_c) state_d = redir_halt_c ? HALT : RUN;
      default: state_d = IDLE;
    endcase
  end

  // Issue, capture and next-pc controls.
  always_comb begin
    issue_c = 1'b0;
    push_c  = 1'b0;
    pc_d    = pc;
    if (state_q == RUN && !redirect_c && !end_c && credit_ok_c) issue_c = 1'b1;
    if (inflight && !end_c && !redirect_c) push_c = 1'b1;
    if (redirect_c)                   pc_d = redir_tgt_c;
    else if (state_q == IDLE && start) pc_d = '0;
    else if (issue_c)                 pc_d = pc + PC_W'(FETCH_BYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      pc       <= pc_d;
      inflight <= issue_c;
      if (issue_c) inflight_pc <= pc;
    end
  end

  assign push_data = '{pc: inflight_pc, inst1: inst1_in, inst2: inst2_in};

  fetch_pair_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data),
    .pop       (pop_c),
    .flush     (redirect_c),
    .count     (count),
    .head      (head)
  );

  assign out_valid = (count != '0);
  assign out_inst1 = out_valid ? head.inst1 : '0;
  assign out_inst2 = out_valid ? head.inst2 : '0;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign halted    = (state_q == HALT) && (count == '0);

`ifdef FETCH_PERF_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_pairs <= '0;
      perf_stall <= '0;
    end else begin
      if (push_c && perf_pairs != 16'hFFFF) perf_pairs <= perf_pairs + 16'd1;
      if (state_q == RUN && !redirect_c && !end_c && !credit_ok_c && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl with a pair-stream scoreboard.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  pc;
  logic [31:0] inst1_in;
  logic [31:0] inst2_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst1;
  logic [31:0] out_inst2;
  logic [7:0]  out_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_pairs;
  logic [15:0] perf_stall;
`endif

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .inst1_in       (inst1_in),
    .inst2_in       (inst2_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst1      (out_inst1),
    .out_inst2      (out_inst2),
    .out_pc         (out_pc),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_pairs     (perf_pairs),
    .perf_stall     (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem1 [32];
  logic [31:0] mem2 [32];

  // Instruction memory: samples pc at each posedge, data valid next cycle.
  always @(posedge clk) begin
    inst1_in <= mem1[pc[7:3]];
    inst2_in <= mem2[pc[7:3]];
  end

  int          errors = 0;
  int          checks = 0;
  int unsigned exp_pc;
  int unsigned last_tgt;
  int unsigned final_pc;
  bit          sb_on;
  int          lat;
  int          vcount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard at the negedge: every accepted pair must be the next one in
  // program order; a redirect restarts the expected order at its target.
  task automatic tick();
    if (sb_on && out_valid && out_ready) begin
      chk("hs_pc",    64'(out_pc),    64'(exp_pc));
      chk("hs_inst1", 64'(out_inst1), 64'(mem1[(exp_pc >> 3) % 32]));
      chk("hs_inst2", 64'(out_inst2), 64'(mem2[(exp_pc >> 3) % 32]));
      chk("hs_range", 64'(exp_pc <= 120), 64'(1));
      exp_pc += 8;
    end
    if (sb_on && redirect_valid) exp_pc = {24'd0, redirect_pc[7:3], 3'b000};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0; sb_on = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem1[i] = $urandom | 32'h1;
      mem2[i] = $urandom;
    end
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    sb_on = 1'b0; exp_pc = 0;
    @(negedge clk);

    // Reset values, then streaming with decode always ready.
    do_reset();
    chk("rst_valid",  64'(out_valid), 64'(0));
    chk("rst_out_pc", 64'(out_pc),    64'(0));
    chk("rst_inst1",  64'(out_inst1), 64'(0));
    chk("rst_inst2",  64'(out_inst2), 64'(0));
    chk("rst_halted", 64'(halted),    64'(0));
    chk("rst_pc",     64'(pc),        64'(0));
    out_ready = 1'b1; exp_pc = 0; sb_on = 1'b1;
    pulse_start();
    chk("lat_c1", 64'(out_valid), 64'(0));
    tick();
    chk("lat_c2", 64'(out_valid), 64'(0));
    tick();
    chk("lat_c3", 64'(out_valid), 64'(1));
    for (int i = 0; i < 16; i++) begin
      chk("tput_valid", 64'(out_valid), 64'(1));
      tick();
    end
    chk("t1_count",  64'(exp_pc),    64'(128));
    chk("t1_halted", 64'(halted),    64'(1));
    chk("t1_valid",  64'(out_valid), 64'(0));

    // Backpressure: two pairs held, pc parked, then in-order release.
    do_reset();
    exp_pc = 0; sb_on = 1'b1;
    pulse_start();
    repeat (10) tick();
    chk("bp_valid", 64'(out_valid), 64'(1));
    chk("bp_head",  64'(out_pc),    64'(0));
    chk("bp_inst1", 64'(out_inst1), 64'(mem1[0]));
    chk("bp_pc",    64'(pc),        64'(16));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_rel_valid", 64'(out_valid), 64'(1));
      tick();
    end
    chk("bp_count", 64'(exp_pc), 64'(64));

    // Redirect to an unaligned target while the queue is full.
    do_reset();
    exp_pc = 0; sb_on = 1'b1;
    pulse_start();
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 8'h2D;
    tick();
    redirect_valid = 1'b0;
    chk("rd_flush", 64'(out_valid), 64'(0));
    chk("rd_pc",    64'(pc),        64'(40));
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    chk("rd_lat", 64'(lat), 64'(2));
    repeat (3) tick();
    chk("rd_count", 64'(exp_pc), 64'(64));

    // End-of-program marker at byte 32.
    mem1[4] = 32'h0;
    do_reset();
    exp_pc = 0; sb_on = 1'b1; out_ready = 1'b1;
    pulse_start();
    repeat (12) tick();
    chk("eop_count",  64'(exp_pc),    64'(32));
    chk("eop_halted", 64'(halted),    64'(1));
    chk("eop_valid",  64'(out_valid), 64'(0));
    mem1[4] = $urandom | 32'h1;

    // Redirect beyond the last legal pair halts the fetch.
    do_reset();
    exp_pc = 0; sb_on = 1'b1; out_ready = 1'b1;
    pulse_start();
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 8'hF8;
    tick();
    redirect_valid = 1'b0;
    vcount = 0;
    repeat (6) begin
      if (out_valid) vcount++;
      tick();
    end
    chk("rhalt_valid",  64'(vcount), 64'(0));
    chk("rhalt_halted", 64'(halted), 64'(1));

    // Reset while a pair is queued and another is in flight.
    do_reset();
    exp_pc = 0; sb_on = 1'b1; out_ready = 1'b1;
    pulse_start();
    repeat (4) tick();
    chk("mrst_pre", 64'(out_valid), 64'(1));
    sb_on = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_valid",  64'(out_valid), 64'(0));
    chk("mrst_halted", 64'(halted),    64'(0));
    chk("mrst_pc",     64'(pc),        64'(0));
    vcount = 0;
    repeat (5) begin
      if (out_valid) vcount++;
      tick();
    end
    chk("mrst_nopush", 64'(vcount), 64'(0));
    chk("mrst_idle",   64'(pc),     64'(0));
    exp_pc = 0; sb_on = 1'b1;
    pulse_start();
    lat = 0;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    chk("mrst_lat", 64'(lat), 64'(2));
    repeat (3) tick();

    // Randomized backpressure and redirects against the scoreboard.
    do_reset();
    exp_pc = 0; last_tgt = 0; sb_on = 1'b1;
    pulse_start();
    for (int i = 0; i < 600; i++) begin
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = 8'($urandom_range(0, 135));
      if (redirect_valid) last_tgt = {24'd0, redirect_pc[7:3], 3'b000};
      tick();
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    lat = 0;
    while (!halted && lat < 100) begin tick(); lat++; end
    final_pc = (last_tgt > 120) ? last_tgt : 128;
    chk("rnd_halted", 64'(halted), 64'(1));
    chk("rnd_final",  64'(exp_pc), 64'(final_pc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
